// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU producers, the arbiter and the register-file write port.
// The slave modport is the arbiter's view of the bus; the master modport is the producer/consumer view.
interface rf_wb_arbiter_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 alu_valid_i;
  logic [4:0]           alu_waddr_i;
  logic [DataWidth-1:0] alu_wdata_i;
  logic                 lsu_valid_i;
  logic                 lsu_ready_o;
  logic [4:0]           lsu_waddr_i;
  logic [DataWidth-1:0] lsu_wdata_i;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 rf_we_o;
  logic [31:0]          pend_mask_o;
  logic [2:0]           fifo_cnt_o;
  logic                 err_o;

  modport slave (
    input  alu_valid_i, alu_waddr_i, alu_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output lsu_ready_o,
    output rf_waddr_o, rf_wdata_o, rf_we_o,
    output pend_mask_o, fifo_cnt_o, err_o
  );

  modport master (
    output alu_valid_i, alu_waddr_i, alu_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  lsu_ready_o,
    input  rf_waddr_o, rf_wdata_o, rf_we_o,
    input  pend_mask_o, fifo_cnt_o, err_o
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU results win each cycle, load responses are buffered
// in order behind them, and one registered write is emitted per cycle.
module rf_wb_arbiter #(
  parameter int unsigned LsuFifoDepth = 2,
  parameter int unsigned DataWidth    = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  rf_wb_arbiter_if.slave bus
);
  typedef struct packed {
    logic [4:0]           addr;
    logic [DataWidth-1:0] data;
  } wb_t;

  localparam logic [2:0] DepthC = 3'(LsuFifoDepth);

  wb_t        fifo_q [LsuFifoDepth];
  wb_t        fifo_d [LsuFifoDepth];
  logic [2:0] cnt_q, cnt_d, push_idx;
  wb_t        out_q, sel_wb;
  logic       we_q, err_q;
  logic       sel_vld, push, pop, lsu_ready, lsu_fire;
  logic [31:0] pend_mask;

  // Ready comes from the registered count, so a full FIFO that pops still refuses a push.
  assign lsu_ready = (cnt_q < DepthC);
  assign lsu_fire  = bus.lsu_valid_i & lsu_ready;

  always_comb begin
    sel_vld = 1'b0;
    sel_wb  = '{addr: bus.alu_waddr_i, data: bus.alu_wdata_i};
    push    = 1'b0;
    pop     = 1'b0;
    if (bus.alu_valid_i) begin
      sel_vld = 1'b1;
      push    = lsu_fire;
    end else if (cnt_q != 3'd0) begin
      sel_vld = 1'b1;
      sel_wb  = fifo_q[0];
      pop     = 1'b1;
      push    = lsu_fire;
    end else if (lsu_fire) begin
      sel_vld = 1'b1;
      sel_wb  = '{addr: bus.lsu_waddr_i, data: bus.lsu_wdata_i};
    end
  end

  // Shift-down FIFO: entry 0 is always the head, tail slot accounts for a same-cycle pop.
  always_comb begin
    push_idx = cnt_q - {2'b00, pop};
    for (int i = 0; i < LsuFifoDepth; i++) begin
      fifo_d[i] = fifo_q[i];
      if (pop && (i < LsuFifoDepth - 1)) fifo_d[i] = fifo_q[i+1];
      if (push && (3'(i) == push_idx))
        fifo_d[i] = '{addr: bus.lsu_waddr_i, data: bus.lsu_wdata_i};
    end
    cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < LsuFifoDepth; i++)
      if (3'(i) < cnt_q) pend_mask[fifo_q[i].addr] = 1'b1;
    if (we_q) pend_mask[out_q.addr] = 1'b1;
    pend_mask[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LsuFifoDepth; i++) fifo_q[i] <= '0;
      cnt_q <= '0;
      out_q <= '0;
      we_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < LsuFifoDepth; i++) fifo_q[i] <= fifo_d[i];
      cnt_q <= cnt_d;
      we_q  <= sel_vld && (sel_wb.addr != 5'd0);
      if (sel_vld) out_q <= sel_wb;
      if (bus.alu_valid_i && (bus.alu_waddr_i != 5'd0) && pend_mask[bus.alu_waddr_i])
        err_q <= 1'b1;
    end
  end

  assign bus.lsu_ready_o = lsu_ready;
  assign bus.rf_we_o     = we_q;
  assign bus.rf_waddr_o  = out_q.addr;
  assign bus.rf_wdata_o  = out_q.data;
  assign bus.pend_mask_o = pend_mask;
  assign bus.fifo_cnt_o  = cnt_q;
  assign bus.err_o       = err_q;
endmodule
